bist_result_display: RTL and testbench



---
 rtl/bist_result_display_if.sv | 20 ++
 rtl/bist_result_display.sv | 131 +++++++++++++
 tb/tb_bist_result_display.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bist_result_display_if.sv
// Bundles the result-bus inputs and display outputs of bist_result_display.
// The master side is the BIST/arithmetic core and its observer; the slave side is the display block.
interface bist_result_display_if;
  logic        busy_i;
  logic [12:0] y_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        valid_o;
  logic        capture_o;

  modport master (
    output busy_i, y_i,
    input  an_o, seg_o, valid_o, capture_o
  );

  modport slave (
    input  busy_i, y_i,
    output an_o, seg_o, valid_o, capture_o
  );
endinterface

// File: rtl/bist_result_display.sv
// Captures the core's 13-bit result on busy falling edge and scans it as four hex digits
// on a multiplexed common-anode 7-segment display (dashes while busy, blank until first capture).
module bist_result_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  bist_result_display_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_BLANK,
    MODE_DASH,
    MODE_HEX
  } mode_e;

  localparam logic [15:0] RCNT_MAX = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_DASH = 7'b0111111;
  localparam logic [6:0]  SEG_OFF  = 7'b1111111;

  logic             busy_q;
  logic [12:0]      result_reg;
  logic             valid_reg;
  logic             capture_reg;
  logic [15:0]      rcnt_reg;
  logic [1:0]       sel_reg;
  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;

  logic             capture_next;
  logic             wrap;
  mode_e            mode_next;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic [3:0][3:0]  digit;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign digit[gi] = result_reg[4*gi+3 -: 4];
    end
  endgenerate
  assign digit[3] = {3'b000, result_reg[12]};

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Mode uses the live busy_i so a new run shows dashes without waiting for a digit change.
  always_comb begin
    capture_next = busy_q & ~bus.busy_i;
    wrap         = (rcnt_reg == RCNT_MAX);
    mode_next    = MODE_HEX;
    an_next      = 4'b1111;
    seg_next     = SEG_OFF;

    if (bus.busy_i) begin
      mode_next = MODE_DASH;
    end else if (!valid_reg) begin
      mode_next = MODE_BLANK;
    end

    case (mode_next)
      MODE_DASH: begin
        an_next  = ~(4'b0001 << sel_reg);
        seg_next = SEG_DASH;
      end
      MODE_HEX: begin
        an_next  = ~(4'b0001 << sel_reg);
        seg_next = hex_glyph(digit[sel_reg]);
      end
      default: begin
        an_next  = 4'b1111;
        seg_next = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= 1'b0;
      result_reg  <= '0;
      valid_reg   <= 1'b0;
      capture_reg <= 1'b0;
      rcnt_reg    <= '0;
      sel_reg     <= '0;
      an_reg      <= 4'b1111;
      seg_reg     <= SEG_OFF;
    end else begin
      busy_q      <= bus.busy_i;
      capture_reg <= capture_next;
      if (capture_next) begin
        result_reg <= bus.y_i;
        valid_reg  <= 1'b1;
      end
      if (wrap) begin
        rcnt_reg <= '0;
        sel_reg  <= sel_reg + 2'd1;
      end else begin
        rcnt_reg <= rcnt_reg + 16'd1;
      end
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign bus.an_o      = an_reg;
  assign bus.seg_o     = seg_reg;
  assign bus.valid_o   = valid_reg;
  assign bus.capture_o = capture_reg;

endmodule

// File: tb/tb_bist_result_display.sv
// Scoreboard bench for bist_result_display: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_bist_result_display;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       valid;
    logic       cap;
  } exp_t;

  localparam logic [6:0] DASH = 7'b0111111;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  exp_t exp_q[$];

  logic [6:0] hexg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Bench-side view of the display state.
  int          ph;
  logic        mb_q;
  logic        m_valid;
  logic [12:0] m_result;

  bist_result_display_if bus ();

  bist_result_display #(.REFRESH_DIV(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc_no, got, exp);
    end
  endtask

  function automatic logic [3:0] digit_of(input logic [12:0] r, input int s);
    case (s)
      0: return r[3:0];
      1: return r[7:4];
      2: return r[11:8];
      default: return {3'b000, r[12]};
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cyc_no++;
      chk("an", 32'(bus.an_o), 32'(e.an));
      chk("seg", 32'(bus.seg_o), 32'(e.seg));
      chk("valid", 32'(bus.valid_o), 32'(e.valid));
      chk("capture", 32'(bus.capture_o), 32'(e.cap));
      $display("cyc %0d busy=%b an=%b seg=%b valid=%b cap=%b", cyc_no, bus.busy_i,
               bus.an_o, bus.seg_o, bus.valid_o, bus.capture_o);
    end
  end

  task automatic model_reset();
    ph = 0;
    mb_q = 1'b0;
    m_valid = 1'b0;
    m_result = '0;
  endtask

  task automatic check_blank(input string tag);
    chk({tag, "_an"}, 32'(bus.an_o), 32'hF);
    chk({tag, "_seg"}, 32'(bus.seg_o), 32'h7F);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
    chk({tag, "_capture"}, 32'(bus.capture_o), 32'h0);
  endtask

  // Drive one cycle of inputs and queue what the display should show after the next edge.
  task automatic cyc(input logic b, input logic [12:0] y);
    exp_t e;
    logic cap;
    int   s;
    bus.busy_i = b;
    bus.y_i    = y;
    cap = mb_q && !b;
    s = (ph / 4) % 4;
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    if (b) begin
      e.an[s] = 1'b0;
      e.seg   = DASH;
    end else if (m_valid) begin
      e.an[s] = 1'b0;
      e.seg   = hexg[digit_of(m_result, s)];
    end
    e.valid = m_valid | cap;
    e.cap   = cap;
    exp_q.push_back(e);
    if (cap) m_result = y;
    m_valid = m_valid | cap;
    mb_q = b;
    ph++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.busy_i = 1'b0;
    bus.y_i    = '0;
    model_reset();
    #3 rst_ni = 1'b0;
    #1 check_blank("reset");
    repeat (2) @(negedge clk);
    #1 rst_ni = 1'b1;

    // Idle after reset: blank, no capture.
    for (int i = 0; i < 40; i++) cyc(1'b0, 13'h0000);

    // First run: dashes while busy, then 0x0251.
    for (int i = 0; i < 20; i++) cyc(1'b1, 13'h0251);
    for (int i = 0; i < 24; i++) cyc(1'b0, 13'h0251);

    // Second run: 0x1ABC; y changes after capture must not alter the display.
    for (int i = 0; i < 12; i++) cyc(1'b1, 13'h1ABC);
    for (int i = 0; i < 24; i++) cyc(1'b0, (i < 2) ? 13'h1ABC : 13'h0F0F);
    for (int i = 0; i < 6; i++) cyc(1'b0, 13'h0F0F);

    // Asynchronous reset while a digit is lit.
    #2 rst_ni = 1'b0;
    #1 check_blank("async_reset");
    repeat (2) begin
      @(negedge clk);
      check_blank("reset_hold");
    end
    #1 rst_ni = 1'b1;
    model_reset();

    // One-cycle busy pulse with y=0.
    for (int i = 0; i < 5; i++) cyc(1'b0, 13'h0000);
    cyc(1'b1, 13'h0000);
    for (int i = 0; i < 20; i++) cyc(1'b0, 13'h0000);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
